// File: rtl/gonso_seq_ctrl_if.sv
// gonso_seq_ctrl_if: register-block, memory-port and datapath signals of the colour sequencer.
// Latency: none (wiring only); timing is owned by gonso_seq_ctrl.
// Backpressure: none; optional abort/aborted members exist only when GONSO_SEQ_ABORT_EN is defined.
interface gonso_seq_ctrl_if #(
    parameter int AW = 6,
    parameter int DW = 8
);
    // register block side
    logic          start;
    logic [3:0]    w_count;
    logic [AW-1:0] w_first;
    logic [AW-1:0] w_last;
    logic          progress;
    logic          done;
    logic [9:0]    words_done;
    // memory port
    logic          cs_n;
    logic          we_n;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    // datapath
    logic [DW-1:0] dp_color_in;
    logic [DW-1:0] dp_color_out;
`ifdef GONSO_SEQ_ABORT_EN
    logic          abort;
    logic          aborted;
`endif

    // sequencer view
    modport master (
        input  start, w_count, w_first, w_last, rdata, dp_color_out,
        output progress, done, words_done, cs_n, we_n, addr, wdata, dp_color_in
`ifdef GONSO_SEQ_ABORT_EN
        , input abort
        , output aborted
`endif
    );

    // register block / memory / datapath view
    modport slave (
        output start, w_count, w_first, w_last, rdata, dp_color_out,
        input  progress, done, words_done, cs_n, we_n, addr, wdata, dp_color_in
`ifdef GONSO_SEQ_ABORT_EN
        , output abort
        , input  aborted
`endif
    );
endinterface

// File: rtl/gonso_seq_ctrl.sv
// gonso_seq_ctrl: walks words w_first..w_last (wrapping mod 64) for w_count passes, read -> datapath -> write back.
// Latency: 3+DP_LATENCY clocks per word (RD, CAP, DP_LATENCY x PROC, WR), plus one DONE clock per sequence.
// Backpressure: none, memory and datapath are fixed-timing; GONSO_SEQ_ABORT_EN adds an abort input that ends the sequence early.
module gonso_seq_ctrl #(
    parameter int DP_LATENCY = 2,   // legal range 1..15
    parameter int AW         = 6,
    parameter int DW         = 8
) (
    input logic              clk,
    input logic              rst,
    gonso_seq_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        PROC = 3'd3,
        WR   = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t        state;
    logic [AW-1:0] cur;        // word currently being processed
    logic [AW-1:0] first_q;    // configuration latched at accepted start
    logic [AW-1:0] last_q;
    logic [3:0]    count_q;
    logic [3:0]    pass_q;     // passes completed so far
    logic [3:0]    lat_cnt;    // datapath latency countdown
    logic [DW-1:0] dp_res;
    logic          abort_req;

    assign dp_res = bus.dp_color_out;

`ifdef GONSO_SEQ_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    // Sequencer FSM; every output is registered and set on entry to the state that owns it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cur             <= '0;
            first_q         <= '0;
            last_q          <= '0;
            count_q         <= '0;
            pass_q          <= '0;
            lat_cnt         <= '0;
            bus.progress    <= 1'b0;
            bus.done        <= 1'b0;
            bus.words_done  <= '0;
            bus.cs_n        <= 1'b1;
            bus.we_n        <= 1'b1;
            bus.addr        <= '0;
            bus.wdata       <= '0;
            bus.dp_color_in <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        first_q        <= bus.w_first;
                        last_q         <= bus.w_last;
                        count_q        <= bus.w_count;
                        cur            <= bus.w_first;
                        pass_q         <= '0;
                        bus.words_done <= '0;
                        bus.progress   <= 1'b1;
                        if (bus.w_count == 4'd0) begin
                            // zero passes: no memory traffic at all
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end else begin
                            state    <= RD;
                            bus.cs_n <= 1'b0;
                            bus.we_n <= 1'b1;
                            bus.addr <= bus.w_first;
                        end
                    end
                end

                RD: begin
                    // the read select is on the bus during this cycle; data returns in CAP
                    bus.cs_n <= 1'b1;
                    if (abort_req) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end else begin
                        state <= CAP;
                    end
                end

                CAP: begin
                    if (abort_req) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end else begin
                        bus.dp_color_in <= bus.rdata;
                        lat_cnt         <= 4'(DP_LATENCY - 1);
                        state           <= PROC;
                    end
                end

                PROC: begin
                    if (abort_req) begin
                        // in-flight word is dropped, never written
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end else if (lat_cnt == 4'd0) begin
                        bus.wdata <= dp_res;
                        bus.cs_n  <= 1'b0;
                        bus.we_n  <= 1'b0;
                        state     <= WR;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end

                WR: begin
                    // the write strobe is on the bus this cycle, so it always completes
                    if (bus.words_done != 10'd1023) begin
                        bus.words_done <= bus.words_done + 10'd1;
                    end
                    bus.we_n <= 1'b1;
                    if (abort_req) begin
                        bus.cs_n <= 1'b1;
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end else if (cur == last_q) begin
                        if (pass_q + 4'd1 == count_q) begin
                            bus.cs_n <= 1'b1;
                            bus.done <= 1'b1;
                            state    <= DONE;
                        end else begin
                            pass_q   <= pass_q + 4'd1;
                            cur      <= first_q;
                            bus.addr <= first_q;
                            bus.cs_n <= 1'b0;
                            state    <= RD;
                        end
                    end else begin
                        // address width gives the mod-64 wrap for w_last < w_first
                        cur      <= cur + 1'b1;
                        bus.addr <= cur + 1'b1;
                        bus.cs_n <= 1'b0;
                        state    <= RD;
                    end
                end

                DONE: begin
                    bus.progress <= 1'b0;
                    state        <= IDLE;
                end

                default: begin
                    bus.progress <= 1'b0;
                    bus.cs_n     <= 1'b1;
                    bus.we_n     <= 1'b1;
                    state        <= IDLE;
                end
            endcase
        end
    end

`ifdef GONSO_SEQ_ABORT_EN
    // Sticky abort flag: rises together with done on an abort, cleared by the next accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.aborted <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            bus.aborted <= 1'b0;
        end else if (bus.abort && (state == RD || state == CAP || state == PROC || state == WR)) begin
            bus.aborted <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_gonso_seq_ctrl.sv
// tb_gonso_seq_ctrl: directed bench for gonso_seq_ctrl with a 64x8 memory model and a +1 datapath model.
// Latency: datapath model result is sampled by the sequencer DP_LATENCY clocks after dp_color_in changes.
// Backpressure: none; abort scenario runs only when GONSO_SEQ_ABORT_EN is defined.
module tb_gonso_seq_ctrl;

    localparam int AW = 6;
    localparam int DW = 8;

    logic clk;
    logic rst;

    gonso_seq_ctrl_if #(.AW(AW), .DW(DW)) bus ();

    gonso_seq_ctrl #(.DP_LATENCY(2), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory model, preload port and activity counters
    logic [DW-1:0] mem [64];
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_dat;
    int            cs_cnt   = 0;
    int            wr_cnt   = 0;
    int            prog_cnt = 0;
    int            done_cnt = 0;
    logic [AW-1:0] wr_log [$];
    logic [DW-1:0] dp_q;

    always @(posedge clk) begin
        if (load_en) mem[load_addr] = load_dat;
        if (bus.cs_n === 1'b0) begin
            cs_cnt = cs_cnt + 1;
            if (bus.we_n === 1'b1) begin
                bus.rdata <= mem[bus.addr];
            end else begin
                mem[bus.addr] = bus.wdata;
                wr_cnt = wr_cnt + 1;
                wr_log.push_back(bus.addr);
            end
        end
    end

    // datapath model: operand+1, one register stage so the result is ready when the sequencer samples it
    always @(posedge clk) dp_q <= bus.dp_color_in + 8'd1;
    assign bus.dp_color_out = dp_q;

    always @(negedge clk) begin
        if (bus.progress === 1'b1) prog_cnt = prog_cnt + 1;
        if (bus.done === 1'b1) done_cnt = done_cnt + 1;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_dat  = d;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    // returns at the first negedge after the accepting edge
    task automatic pulse_start(input logic [AW-1:0] f, input logic [AW-1:0] l, input logic [3:0] c);
        bus.w_first = f;
        bus.w_last  = l;
        bus.w_count = c;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
    endtask

    // n = 1 at the first sample after the accepting edge
    task automatic wait_done(input int max, output int n);
        n = 1;
        while (bus.done !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int w0;
        int c0;
        int d0;
        int p0;
        int l0;

        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.w_count = '0;
        bus.w_first = '0;
        bus.w_last  = '0;
        load_en     = 1'b0;
        load_addr   = '0;
        load_dat    = '0;
`ifdef GONSO_SEQ_ABORT_EN
        bus.abort   = 1'b0;
`endif
        repeat (3) @(negedge clk);

        // reset state
        check("rst_progress", 32'(bus.progress), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_words_done", 32'(bus.words_done), 0);
        check("rst_cs_n", 32'(bus.cs_n), 1);
        check("rst_we_n", 32'(bus.we_n), 1);
        check("rst_addr", 32'(bus.addr), 0);
        check("rst_wdata", 32'(bus.wdata), 0);
        check("rst_dp_in", 32'(bus.dp_color_in), 0);
`ifdef GONSO_SEQ_ABORT_EN
        check("rst_aborted", 32'(bus.aborted), 0);
`endif

        load(6'd2, 8'd10);  load(6'd3, 8'd20);  load(6'd4, 8'd255); load(6'd5, 8'h55);
        load(6'd62, 8'd40); load(6'd63, 8'd50); load(6'd0, 8'd60);  load(6'd1, 8'd70);
        load(6'd7, 8'd0);   load(6'd10, 8'd100); load(6'd11, 8'd110);
        load(6'd20, 8'd5);  load(6'd21, 8'd6);
        rst = 1'b0;
        @(negedge clk);

        // three words, one pass: 3*(3+2) word cycles then DONE
        w0 = wr_cnt; c0 = cs_cnt;
        pulse_start(6'd2, 6'd4, 4'd1);
        check("t1_progress_up", 32'(bus.progress), 1);
        check("t1_first_rd_cs", 32'(bus.cs_n), 0);
        wait_done(40, n);
        check("t1_done_seen", 32'(bus.done), 1);
        check("t1_latency", n, 16);
        check("t1_words_done", 32'(bus.words_done), 3);
        @(negedge clk);
        check("t1_done_pulse", 32'(bus.done), 0);
        check("t1_progress_down", 32'(bus.progress), 0);
        check("t1_writes", wr_cnt - w0, 3);
        check("t1_cs_cycles", cs_cnt - c0, 6);
        check("t1_mem2", 32'(mem[2]), 11);
        check("t1_mem3", 32'(mem[3]), 21);
        check("t1_mem4_wrap", 32'(mem[4]), 0);

        // address wrap 62,63,0,1
        l0 = wr_log.size();
        pulse_start(6'd62, 6'd1, 4'd1);
        wait_done(40, n);
        check("t2_latency", n, 21);
        @(negedge clk);
        check("t2_nwrites", wr_log.size() - l0, 4);
        if (wr_log.size() >= l0 + 4) begin
            check("t2_order0", 32'(wr_log[l0]), 62);
            check("t2_order1", 32'(wr_log[l0+1]), 63);
            check("t2_order2", 32'(wr_log[l0+2]), 0);
            check("t2_order3", 32'(wr_log[l0+3]), 1);
        end
        check("t2_mem62", 32'(mem[62]), 41);
        check("t2_mem0", 32'(mem[0]), 61);
        check("t2_mem1", 32'(mem[1]), 71);
        check("t2_mem5_untouched", 32'(mem[5]), 32'h55);

        // single word, three passes
        p0 = prog_cnt;
        pulse_start(6'd7, 6'd7, 4'd3);
        wait_done(40, n);
        check("t3_latency", n, 16);
        @(negedge clk);
        check("t3_progress_cycles", prog_cnt - p0, 16);
        check("t3_mem7", 32'(mem[7]), 3);
        check("t3_words_done", 32'(bus.words_done), 3);

        // zero passes: straight to DONE, no memory access, counter cleared
        c0 = cs_cnt; d0 = done_cnt;
        pulse_start(6'd3, 6'd3, 4'd0);
        check("t4_done_now", 32'(bus.done), 1);
        check("t4_words_done", 32'(bus.words_done), 0);
        @(negedge clk);
        check("t4_done_pulse", 32'(bus.done), 0);
        check("t4_progress_down", 32'(bus.progress), 0);
        @(negedge clk);
        check("t4_no_cs", cs_cnt - c0, 0);
        check("t4_done_count", done_cnt - d0, 1);

        // start re-pulsed mid-sequence is ignored; reset in PROC of the second word aborts cleanly
        w0 = wr_cnt; d0 = done_cnt;
        pulse_start(6'd10, 6'd11, 4'd2);        // now in RD
        bus.w_count = 4'd0;
        bus.w_first = 6'd0;
        bus.w_last  = 6'd0;
        bus.start   = 1'b1;
        @(negedge clk);                          // CAP
        bus.start   = 1'b0;
        check("t5_repulse_progress", 32'(bus.progress), 1);
        check("t5_cap_cs", 32'(bus.cs_n), 1);
        repeat (4) @(negedge clk);               // RD of word 11
        check("t5_words_done_1", 32'(bus.words_done), 1);
        check("t5_rd_addr", 32'(bus.addr), 11);
        repeat (2) @(negedge clk);               // PROC
        check("t5_proc_cs", 32'(bus.cs_n), 1);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_progress", 32'(bus.progress), 0);
        check("t5_rst_cs_n", 32'(bus.cs_n), 1);
        check("t5_rst_we_n", 32'(bus.we_n), 1);
        check("t5_rst_words_done", 32'(bus.words_done), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("t5_writes", wr_cnt - w0, 1);
        check("t5_no_done", done_cnt - d0, 0);
        check("t5_mem10", 32'(mem[10]), 101);
        check("t5_mem11_untouched", 32'(mem[11]), 110);
        check("t5_idle_progress", 32'(bus.progress), 0);

`ifdef GONSO_SEQ_ABORT_EN
        // abort in the second word's PROC: word 20 written, word 21 not
        w0 = wr_cnt;
        pulse_start(6'd20, 6'd22, 4'd1);         // RD of word 20
        repeat (7) @(negedge clk);               // first PROC of word 21
        check("t6_proc_cs", 32'(bus.cs_n), 1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("t6_done", 32'(bus.done), 1);
        check("t6_aborted", 32'(bus.aborted), 1);
        check("t6_words_done", 32'(bus.words_done), 1);
        @(negedge clk);
        check("t6_done_pulse", 32'(bus.done), 0);
        check("t6_aborted_sticky", 32'(bus.aborted), 1);
        repeat (3) @(negedge clk);
        check("t6_writes", wr_cnt - w0, 1);
        check("t6_mem20", 32'(mem[20]), 6);
        check("t6_mem21_untouched", 32'(mem[21]), 6);
        pulse_start(6'd22, 6'd22, 4'd0);
        check("t6_aborted_cleared", 32'(bus.aborted), 0);
        repeat (2) @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
